decode_mac_pipe: RTL

Parametrised successor to the decode datapath's fixed two-stage signed multiplier. It multiplies two signed operands through a configurable-depth pipeline with a valid/ready handshake. It can either emit each product or accumulate a framed sequence of products, and the output is round-shifted and saturated to a fixed-point result. It sits between the operand fetch logic and the CNN decode output writer.

---
 rtl/decode_mac_pkg.sv | 60 ++++++
 rtl/decode_mul_pipe.sv | 52 +++++
 rtl/decode_mac_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/decode_mac_pkg.sv
// Shared types, width helpers and the round/saturate conversion
// for the decode multiply-accumulate pipeline.
package decode_mac_pkg;

    // Widest value the conversion helper accepts; must exceed any ACC_WIDTH used.
    localparam int unsigned MaxWidth = 128;

    localparam int unsigned DefDin0Width = 16;
    localparam int unsigned DefDin1Width = 16;
    localparam int unsigned DefGuard     = 8;
    localparam int unsigned DefAccWidth  = DefDin0Width + DefDin1Width + DefGuard;

    typedef struct packed {
        logic valid;
        logic acc_en;
        logic first;
        logic last;
    } sideband_t;

    typedef struct packed {
        logic signed [MaxWidth-1:0] value;
        logic                       sat;
    } conv_t;

    function automatic int unsigned acc_width(input int unsigned din0_w,
                                              input int unsigned din1_w,
                                              input int unsigned guard);
        return din0_w + din1_w + guard;
    endfunction

    // Round half toward +inf, drop `shift` fraction bits, clamp to a dout_w-bit signed range.
    function automatic conv_t round_sat(input logic signed [MaxWidth-1:0] value,
                                        input int unsigned                shift,
                                        input int unsigned                dout_w);
        logic signed [MaxWidth-1:0] half;
        logic signed [MaxWidth-1:0] r;
        logic signed [MaxWidth-1:0] hi;
        logic signed [MaxWidth-1:0] lo;
        conv_t                      res;
        half = '0;
        if (shift > 0) begin
            half = MaxWidth'(1) << (shift - 1);
        end
        r  = (value + half) >>> shift;
        hi = (MaxWidth'(1) << (dout_w - 1)) - MaxWidth'(1);
        lo = -hi - MaxWidth'(1);
        if (r > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (r < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end else begin
            res.value = r;
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/decode_mul_pipe.sv
// Signed multiplier with NUM_STAGE pipeline registers; the per-beat sideband
// travels alongside the product and every stage advances only on en_i.
module decode_mul_pipe
    import decode_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 16,
    parameter int unsigned DIN1_WIDTH = 16,
    parameter int unsigned NUM_STAGE  = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   en_i,
    input  logic signed [DIN0_WIDTH-1:0]           din0_i,
    input  logic signed [DIN1_WIDTH-1:0]           din1_i,
    input  sideband_t                              sb_i,
    output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] prod_o,
    output sideband_t                              sb_o
);

    localparam int unsigned ProdWidth = DIN0_WIDTH + DIN1_WIDTH;

    logic signed [ProdWidth-1:0] din0_ext;
    logic signed [ProdWidth-1:0] din1_ext;
    logic signed [ProdWidth-1:0] prod_d;
    logic signed [ProdWidth-1:0] prod_q [NUM_STAGE];
    sideband_t                   sb_q   [NUM_STAGE];

    // Full-width operands make the truncated product exact.
    assign din0_ext = {{DIN1_WIDTH{din0_i[DIN0_WIDTH-1]}}, din0_i};
    assign din1_ext = {{DIN0_WIDTH{din1_i[DIN1_WIDTH-1]}}, din1_i};
    assign prod_d   = din0_ext * din1_ext;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
                sb_q[i]   <= '0;
            end
        end else if (en_i) begin
            prod_q[0] <= prod_d;
            sb_q[0]   <= sb_i;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                sb_q[i]   <= sb_q[i-1];
            end
        end
    end

    assign prod_o = prod_q[NUM_STAGE-1];
    assign sb_o   = sb_q[NUM_STAGE-1];

endmodule

// File: rtl/decode_mac_pipe.sv
// Pipelined signed multiply / framed accumulate with valid-ready handshake and a
// registered round-and-saturate output stage.
module decode_mac_pipe
    import decode_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 16,
    parameter int unsigned DIN1_WIDTH = 16,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned GUARD      = 8,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned DOUT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ce_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DIN0_WIDTH-1:0] din0_i,
    input  logic signed [DIN1_WIDTH-1:0] din1_i,
    input  logic                         acc_en_i,
    input  logic                         in_first_i,
    input  logic                         in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DOUT_WIDTH-1:0] dout_o,
    output logic                         out_sat_o
);

    localparam int unsigned ACC_WIDTH  = acc_width(DIN0_WIDTH, DIN1_WIDTH, GUARD);
    localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    logic                         adv;
    sideband_t                    sb_in;
    sideband_t                    sb_fin;
    logic signed [PROD_WIDTH-1:0] prod_fin;

    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_base;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic                         acc_clear_q;
    logic                         acc_clear_d;
    logic                         emit;
    logic signed [ACC_WIDTH-1:0]  value;

    logic signed [MaxWidth-1:0]   value_wide;
    conv_t                        conv;
    logic                         unused_conv;

    logic                         out_valid_q;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic signed [DOUT_WIDTH-1:0] dout_d;
    logic                         out_sat_q;
    logic                         out_sat_d;

    // One shared advance keeps bubbles in place and never drops a beat.
    assign adv        = ce_i && (!out_valid_q || out_ready_i);
    assign in_ready_o = adv;

    assign sb_in = '{valid: in_valid_i, acc_en: acc_en_i, first: in_first_i, last: in_last_i};

    decode_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_STAGE  (NUM_STAGE)
    ) u_mul_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (adv),
        .din0_i (din0_i),
        .din1_i (din1_i),
        .sb_i   (sb_in),
        .prod_o (prod_fin),
        .sb_o   (sb_fin)
    );

    always_comb begin
        prod_ext    = {{(ACC_WIDTH-PROD_WIDTH){prod_fin[PROD_WIDTH-1]}}, prod_fin};
        acc_base    = (sb_fin.first || acc_clear_q) ? '0 : acc_q;
        acc_sum     = acc_base + prod_ext;
        acc_d       = acc_q;
        acc_clear_d = acc_clear_q;
        emit        = 1'b0;
        value       = prod_ext;
        if (sb_fin.valid) begin
            if (!sb_fin.acc_en) begin
                emit = 1'b1;
            end else begin
                acc_d = acc_sum;
                if (sb_fin.last) begin
                    // Closing a frame arms the clear so the next frame needs no first flag.
                    emit        = 1'b1;
                    value       = acc_sum;
                    acc_clear_d = 1'b1;
                end else begin
                    acc_clear_d = 1'b0;
                end
            end
        end
    end

    assign value_wide  = {{(MaxWidth-ACC_WIDTH){value[ACC_WIDTH-1]}}, value};
    assign conv        = round_sat(value_wide, SHIFT, DOUT_WIDTH);
    assign dout_d      = conv.value[DOUT_WIDTH-1:0];
    assign out_sat_d   = conv.sat;
    assign unused_conv = ^conv.value[MaxWidth-1:DOUT_WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            acc_clear_q <= 1'b1;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            acc_q       <= acc_d;
            acc_clear_q <= acc_clear_d;
            out_valid_q <= emit;
            if (emit) begin
                dout_q    <= dout_d;
                out_sat_q <= out_sat_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign dout_o      = dout_q;
    assign out_sat_o   = out_sat_q;

endmodule
